// File: rtl/psum_ctrl_pkg.sv
// Shared types and defaults for the PE partial-sum stage sequencer.
package psum_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ACC, OUT, DONE} psum_ctrl_state_e;

  localparam int NACC_WD_DEF = 8;
  localparam int NPIX_WD_DEF = 8;
  localparam int PERF_CNT_WD = 32;
endpackage

// File: rtl/psum_ctrl_if.sv
// Config, pixel handshakes and sum-stage strobes of one psum_ctrl instance.
interface psum_ctrl_if #(
  parameter int NACC_WD = 8,
  parameter int NPIX_WD = 8
);
  logic               i_cfg_valid, o_cfg_ready;
  logic [NACC_WD-1:0] i_cfg_nacc;
  logic [NPIX_WD-1:0] i_cfg_npix;
  logic               i_cfg_read_psum;
  logic               i_sum_valid, o_sum_ready;
  logic               i_psum_valid, o_psum_ready;
  logic               o_psum_valid, i_psum_ready;
  logic               o_cont_reset, o_cont_stall, o_cont_first_pix;
  logic               o_cont_read_psum, o_cont_forward;
  logic               o_busy, o_done;

  modport master (
    output i_cfg_valid, i_cfg_nacc, i_cfg_npix, i_cfg_read_psum,
           i_sum_valid, i_psum_valid, i_psum_ready,
    input  o_cfg_ready, o_sum_ready, o_psum_ready, o_psum_valid,
           o_cont_reset, o_cont_stall, o_cont_first_pix, o_cont_read_psum,
           o_cont_forward, o_busy, o_done
  );

  modport slave (
    input  i_cfg_valid, i_cfg_nacc, i_cfg_npix, i_cfg_read_psum,
           i_sum_valid, i_psum_valid, i_psum_ready,
    output o_cfg_ready, o_sum_ready, o_psum_ready, o_psum_valid,
           o_cont_reset, o_cont_stall, o_cont_first_pix, o_cont_read_psum,
           o_cont_forward, o_busy, o_done
  );
endinterface

// File: rtl/psum_ctrl_cnt_max.sv
// Clearable up-counter that wraps to zero after reaching max; hit flags cnt==max.
module psum_cnt_max #(
  parameter int WD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [WD-1:0] max,
  output logic [WD-1:0] cnt,
  output logic          hit
);
  assign hit = (cnt == max);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (inc)      cnt <= hit ? '0 : cnt + WD'(1);
  end
endmodule

// File: rtl/psum_ctrl.sv
// Partial-sum stage sequencer: job config, sum-stage strobes, pixel handshakes.
// Define PSUM_CTRL_PERF_EN to add the saturating busy-stall cycle counter o_stall_cnt.
module psum_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int NACC_WD = NACC_WD_DEF,
  parameter int NPIX_WD = NPIX_WD_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  psum_ctrl_if.slave bus
`ifdef PSUM_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_WD-1:0] o_stall_cnt
`endif
);
  psum_ctrl_state_e   state_q, state_d;
  logic [NACC_WD-1:0] nacc_max_q, acc_cnt;
  logic [NPIX_WD-1:0] npix_max_q, pix_cnt;
  logic               read_psum_q, acc_hit, pix_hit;
  logic               cfg_acc, needp, beat, out_hs;

  assign cfg_acc = bus.i_cfg_valid && (state_q == IDLE);
  assign needp   = (acc_cnt == '0) && read_psum_q;
  assign beat    = (state_q == ACC) && bus.i_sum_valid && (!needp || bus.i_psum_valid);
  assign out_hs  = (state_q == OUT) && bus.i_psum_ready;

  // Config counts are stored as max(cfg,1)-1 so the counters compare directly.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      nacc_max_q  <= '0;
      npix_max_q  <= '0;
      read_psum_q <= 1'b0;
    end else if (cfg_acc) begin
      nacc_max_q  <= (bus.i_cfg_nacc == '0) ? '0 : bus.i_cfg_nacc - NACC_WD'(1);
      npix_max_q  <= (bus.i_cfg_npix == '0) ? '0 : bus.i_cfg_npix - NPIX_WD'(1);
      read_psum_q <= bus.i_cfg_read_psum;
    end
  end

  psum_cnt_max #(.WD(NACC_WD)) u_acc_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(cfg_acc), .inc(beat),
    .max(nacc_max_q), .cnt(acc_cnt), .hit(acc_hit)
  );

  psum_cnt_max #(.WD(NPIX_WD)) u_pix_cnt (
    .clk(i_clk), .rst_n(i_rst_n), .clr(cfg_acc), .inc(out_hs),
    .max(npix_max_q), .cnt(pix_cnt), .hit(pix_hit)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_cfg_valid) state_d = ACC;
      ACC:     if (beat && acc_hit) state_d = OUT;
      OUT:     if (bus.i_psum_ready) state_d = pix_hit ? DONE : ACC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_cfg_ready      = 1'b0;
    bus.o_sum_ready      = 1'b0;
    bus.o_psum_ready     = 1'b0;
    bus.o_psum_valid     = 1'b0;
    bus.o_cont_reset     = 1'b0;
    bus.o_cont_stall     = 1'b0;
    bus.o_cont_first_pix = 1'b0;
    bus.o_cont_read_psum = 1'b0;
    bus.o_cont_forward   = 1'b0;
    bus.o_busy           = (state_q != IDLE);
    bus.o_done           = 1'b0;
    case (state_q)
      IDLE: begin
        bus.o_cfg_ready  = 1'b1;
        bus.o_cont_reset = 1'b1;
        bus.o_cont_stall = 1'b1;
      end
      ACC: begin
        // sum_ready must not depend on i_sum_valid or i_psum_ready.
        bus.o_sum_ready      = !needp || bus.i_psum_valid;
        bus.o_psum_ready     = needp && bus.i_sum_valid;
        bus.o_cont_first_pix = beat && (acc_cnt == '0);
        bus.o_cont_read_psum = beat && needp;
        bus.o_cont_stall     = !beat;
      end
      OUT: begin
        bus.o_psum_valid   = 1'b1;
        bus.o_cont_forward = 1'b1;
        bus.o_cont_stall   = !bus.i_psum_ready;
      end
      DONE: begin
        bus.o_done       = 1'b1;
        bus.o_cont_reset = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PSUM_CTRL_PERF_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || cfg_acc)
      o_stall_cnt <= '0;
    else if (bus.o_busy && bus.o_cont_stall && !(&o_stall_cnt))
      o_stall_cnt <= o_stall_cnt + PERF_CNT_WD'(1);
  end
`endif
endmodule

// File: tb/tb_psum_ctrl.sv
// Directed bench for psum_ctrl: job-level model checked every cycle plus literal job metrics.
module tb_psum_ctrl;
  import psum_ctrl_pkg::*;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  psum_ctrl_if #(.NACC_WD(8), .NPIX_WD(8)) pif ();
`ifdef PSUM_CTRL_PERF_EN
  logic [31:0] stall_cnt;
`endif

  psum_ctrl #(.NACC_WD(8), .NPIX_WD(8)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .bus(pif)
`ifdef PSUM_CTRL_PERF_EN
    , .o_stall_cnt(stall_cnt)
`endif
  );

  typedef struct packed {
    logic cfg_ready, sum_ready, psum_ready, psum_valid, reset, stall;
    logic first_pix, read_psum, forward, busy, done;
  } outs_t;

  int n_chk = 0, n_fail = 0;

  // Job model: progress kept as total beats B and pixels emitted O.
  int m_active = 0, m_done = 0, m_n = 1, m_p = 1, m_rp = 0, m_B = 0, m_O = 0;
  int unsigned m_stall = 0;

  function automatic int m_phase();
    if (m_done != 0)            return 3;
    if (m_active == 0)          return 0;
    if (m_B == (m_O + 1) * m_n) return 2;
    return 1;
  endfunction

  function automatic outs_t exp_outs();
    outs_t e = '0;
    logic needp, beat;
    case (m_phase())
      0: begin e.cfg_ready = 1; e.reset = 1; e.stall = 1; end
      1: begin
        needp = (m_rp != 0) && (m_B % m_n == 0);
        e.sum_ready  = !needp || pif.i_psum_valid;
        e.psum_ready = needp && pif.i_sum_valid;
        beat         = pif.i_sum_valid && e.sum_ready;
        e.first_pix  = beat && (m_B % m_n == 0);
        e.read_psum  = beat && needp;
        e.stall      = !beat;
        e.busy       = 1;
      end
      2: begin e.psum_valid = 1; e.forward = 1; e.stall = !pif.i_psum_ready; e.busy = 1; end
      default: begin e.done = 1; e.reset = 1; e.busy = 1; end
    endcase
    return e;
  endfunction

  always @(posedge i_clk) begin
    outs_t e;
    int ph;
    e = exp_outs();
    ph = m_phase();
    if (!i_rst_n) begin
      m_active = 0; m_done = 0; m_stall = 0;
    end else begin
      if (ph == 0 && pif.i_cfg_valid) m_stall = 0;
      else if (e.busy && e.stall && m_stall != 32'hffff_ffff) m_stall++;
      case (ph)
        0: if (pif.i_cfg_valid) begin
          m_active = 1; m_B = 0; m_O = 0;
          m_n  = (pif.i_cfg_nacc == 0) ? 1 : int'(pif.i_cfg_nacc);
          m_p  = (pif.i_cfg_npix == 0) ? 1 : int'(pif.i_cfg_npix);
          m_rp = int'(pif.i_cfg_read_psum);
        end
        1: if (pif.i_sum_valid && e.sum_ready) m_B++;
        2: if (pif.i_psum_ready) begin
          m_O++;
          if (m_O == m_p) begin m_done = 1; m_active = 0; end
        end
        default: m_done = 0;
      endcase
    end
  end

  // Observed job metrics, cleared at each job start.
  int cyc = 0, cfg_cyc, done_cyc, fb_cyc, pv0_cyc, pv1_cyc, rp_cyc;
  int n_beats, n_out_hs, n_done, n_rp, n_out_stall, n_acc_stall, n_cfg, n_pr_hs;
  int fp_mask;
  logic prev_pv = 1'b0;

  always @(negedge i_clk) begin
    outs_t e, a;
    e = exp_outs();
    a = '{pif.o_cfg_ready, pif.o_sum_ready, pif.o_psum_ready, pif.o_psum_valid,
          pif.o_cont_reset, pif.o_cont_stall, pif.o_cont_first_pix,
          pif.o_cont_read_psum, pif.o_cont_forward, pif.o_busy, pif.o_done};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL outs cyc=%0d got=%b exp=%b", cyc, a, e);
    end
`ifdef PSUM_CTRL_PERF_EN
    n_chk++;
    if (stall_cnt !== m_stall) begin
      n_fail++;
      $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stall);
    end
`endif
    if (pif.i_cfg_valid && pif.o_cfg_ready) begin cfg_cyc = cyc; n_cfg++; end
    if (pif.i_sum_valid && pif.o_sum_ready) begin
      if (n_beats == 0) fb_cyc = cyc;
      if (pif.o_cont_first_pix && n_beats < 31) fp_mask |= (1 << n_beats);
      n_beats++;
    end
    if (pif.o_cont_read_psum) begin n_rp++; rp_cyc = cyc; end
    if (pif.o_psum_ready && pif.i_psum_valid) n_pr_hs++;
    if (pif.o_psum_valid && !prev_pv) begin
      if (pv0_cyc < 0) pv0_cyc = cyc; else if (pv1_cyc < 0) pv1_cyc = cyc;
    end
    prev_pv = pif.o_psum_valid;
    if (pif.o_psum_valid && pif.i_psum_ready) n_out_hs++;
    if (pif.o_psum_valid && pif.o_cont_stall) n_out_stall++;
    if (pif.o_busy && !pif.o_psum_valid && !pif.o_done && pif.o_cont_stall) n_acc_stall++;
    if (pif.o_done) begin n_done++; done_cyc = cyc; end
    cyc++;
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic start_job(input int nacc, input int npix, input bit rp);
    cfg_cyc = -1; done_cyc = -1; fb_cyc = -1; pv0_cyc = -1; pv1_cyc = -1; rp_cyc = -1;
    n_beats = 0; n_out_hs = 0; n_done = 0; n_rp = 0; n_out_stall = 0;
    n_acc_stall = 0; n_cfg = 0; n_pr_hs = 0; fp_mask = 0;
    pif.i_cfg_nacc = 8'(nacc); pif.i_cfg_npix = 8'(npix); pif.i_cfg_read_psum = rp;
    pif.i_cfg_valid = 1'b1;
    step();
    pif.i_cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 300 && n_done == 0; i++) step();
    if (n_done == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout waiting for done", name);
    end
  endtask

  initial begin
    pif.i_cfg_valid = 0; pif.i_cfg_nacc = 0; pif.i_cfg_npix = 0; pif.i_cfg_read_psum = 0;
    pif.i_sum_valid = 1; pif.i_psum_valid = 0; pif.i_psum_ready = 1;
    step(); step();
    chk("rst_cfg_ready", pif.o_cfg_ready, 1);
    chk("rst_cont_reset", pif.o_cont_reset, 1);
    chk("rst_cont_stall", pif.o_cont_stall, 1);
    chk("rst_busy", pif.o_busy, 0);
    i_rst_n = 1'b1;
    step();

    // Basic 3x2 job
    start_job(3, 2, 0);
    wait_done("t1");
    chk("t1_cfg_to_beat", fb_cyc - cfg_cyc, 1);
    chk("t1_fp_mask", fp_mask, 9);
    chk("t1_pv0", pv0_cyc - fb_cyc + 1, 4);
    chk("t1_pv1", pv1_cyc - fb_cyc + 1, 8);
    chk("t1_len", done_cyc - fb_cyc + 1, 9);
    chk("t1_outs", n_out_hs, 2);
    chk("t1_done", n_done, 1);

    // Back-pressure on first output pixel
    start_job(3, 2, 0);
    for (int i = 0; i < 50 && !pif.o_psum_valid; i++) step();
    pif.i_psum_ready = 0;
    step(); step(); step();
    pif.i_psum_ready = 1;
    wait_done("t2");
    chk("t2_out_stall", n_out_stall, 3);
    chk("t2_outs", n_out_hs, 2);
    chk("t2_beats", n_beats, 6);
    chk("t2_len", done_cyc - fb_cyc + 1, 12);
`ifdef PSUM_CTRL_PERF_EN
    chk("t2_stall_cnt", int'(stall_cnt), 3);
`endif

    // Upstream psum arrives two cycles late
    pif.i_psum_valid = 0;
    start_job(2, 1, 1);
    step(); step();
    pif.i_psum_valid = 1;
    wait_done("t3");
    pif.i_psum_valid = 0;
    chk("t3_first_beat", fb_cyc - cfg_cyc, 3);
    chk("t3_rp_cnt", n_rp, 1);
    chk("t3_rp_cyc", rp_cyc - fb_cyc, 0);
    chk("t3_psum_hs", n_pr_hs, 1);
    chk("t3_acc_stall", n_acc_stall, 2);
    chk("t3_len", done_cyc - cfg_cyc, 6);
`ifdef PSUM_CTRL_PERF_EN
    chk("t3_stall_cnt", int'(stall_cnt), 2);
`endif

    // Zero counts behave as 1/1
    start_job(0, 0, 0);
    wait_done("t4");
    chk("t4_len", done_cyc - cfg_cyc, 3);
    chk("t4_beats", n_beats, 1);
    chk("t4_outs", n_out_hs, 1);

    // Reset mid-accumulation, then a fresh job
    start_job(3, 1, 0);
    step();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    chk("t5_cfg_ready", pif.o_cfg_ready, 1);
    chk("t5_cont_reset", pif.o_cont_reset, 1);
    chk("t5_busy", pif.o_busy, 0);
    chk("t5_sum_ready", pif.o_sum_ready, 0);
    start_job(3, 2, 0);
    wait_done("t5");
    chk("t5_fp_mask", fp_mask, 9);
    chk("t5_outs", n_out_hs, 2);
    chk("t5_len", done_cyc - fb_cyc + 1, 9);

    // Config while busy is ignored
    start_job(2, 2, 0);
    step();
    pif.i_cfg_nacc = 8'd5; pif.i_cfg_npix = 8'd5; pif.i_cfg_valid = 1'b1;
    step();
    pif.i_cfg_valid = 1'b0;
    wait_done("t6");
    chk("t6_cfg_acc", n_cfg, 1);
    chk("t6_beats", n_beats, 4);
    chk("t6_outs", n_out_hs, 2);
    chk("t6_done", n_done, 1);

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
